fetch_pc_sequencer: RTL and testbench

Fetch-stage controller that owns the program counter and drives the instruction-memory request handshake for the 32-bit RISC-V core. It shares one 32-bit adder between sequential increment (PC+4) and redirect target generation (base+offset). It applies trap and branch/jump redirects with fixed priority and discards in-flight fetches made stale by a redirect. It sits between the instruction memory port and the decode stage.

---
 rtl/fetch_pc_sequencer_pkg.sv | 17 +
 rtl/fetch_pc_sequencer_pc_add32.sv | 12 +
 rtl/fetch_pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_pc_sequencer_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/fetch_pc_sequencer_pc_add32.sv
// Plain 32-bit modulo adder shared by PC increment and redirect target generation.
module pc_add32
    import fetch_pc_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC owner and instruction-memory handshake controller.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on redirect targets with bit 1 set.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trap_i,
    input  logic        redirect_i,
    input  logic [31:0] redir_base_i,
    input  logic [31:0] redir_off_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    input  logic        if_ready_i,
    output logic        misalign_o
);

    state_e            state, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_d;
    logic [XLEN-1:0]   instr, instr_d;
    logic              kill, kill_d;

    logic [XLEN-1:0]   add_a, add_b, sum;
    logic [XLEN-1:0]   redir_pc;
    logic              redir_any;

    // One adder: redirect target when redirect_i is high, otherwise pc+4.
    assign add_a = redirect_i ? redir_base_i : pc;
    assign add_b = redirect_i ? redir_off_i  : PC_INC;

    pc_add32 u_pc_add32 (
        .a (add_a),
        .b (add_b),
        .y (sum)
    );

    assign redir_any = trap_i | redirect_i;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_d, misalign_q;

    // Trap wins; a redirect target with bit 1 set diverts to the trap vector.
    always_comb begin
        redir_pc   = TRAP_VEC;
        misalign_d = 1'b0;
        if (!trap_i && redirect_i) begin
            if (sum[1]) begin
                misalign_d = 1'b1;
            end else begin
                redir_pc = {sum[XLEN-1:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    // Trap wins; redirect targets are forced to word alignment.
    always_comb begin
        redir_pc = TRAP_VEC;
        if (!trap_i && redirect_i) begin
            redir_pc = {sum[XLEN-1:2], 2'b00};
        end
    end

    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            fetch_pc <= '0;
            instr    <= '0;
            kill     <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            fetch_pc <= fetch_pc_d;
            instr    <= instr_d;
            kill     <= kill_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        fetch_pc_d = fetch_pc;
        instr_d    = instr;
        kill_d     = kill;

        case (state)
            BOOT: state_d = REQ;

            REQ: begin
                if (imem_gnt_i) begin
                    state_d    = WAIT;
                    fetch_pc_d = pc;
                    if (redir_any) begin
                        kill_d = 1'b1;
                    end else begin
                        pc_d = sum;
                    end
                end
            end

            WAIT: begin
                // A response that coincides with a redirect is stale as well.
                if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (kill || redir_any) begin
                        state_d = REQ;
                    end else begin
                        instr_d = imem_rdata_i;
                        state_d = HOLD;
                    end
                end else if (redir_any) begin
                    kill_d = 1'b1;
                end
            end

            HOLD: begin
                if (redir_any || if_ready_i) begin
                    state_d = REQ;
                end
            end

            default: state_d = BOOT;
        endcase

        if (redir_any) begin
            pc_d = redir_pc;
        end
    end

    assign imem_req_o  = (state == REQ);
    assign imem_addr_o = pc;
    assign if_valid_o  = (state == HOLD);
    assign if_instr_o  = (state == HOLD) ? instr    : '0;
    assign if_pc_o     = (state == HOLD) ? fetch_pc : '0;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vector table, reset corner case, randomized run against a fetch-stream model.
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        trap_i;
    logic        redirect_i;
    logic [31:0] redir_base_i;
    logic [31:0] redir_off_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_ready_i;
    logic        misalign_o;

    localparam logic [31:0] TRAP = 32'h0000_0100;
    localparam logic [31:0] I0   = 32'h0000_0013;
    localparam logic [31:0] I1   = 32'h0040_0093;
    localparam logic [31:0] I2   = 32'h0080_0113;
    localparam logic [31:0] I3   = 32'h00C0_0193;
    localparam logic [31:0] I4   = 32'h1234_5678;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] T202 = 32'h0000_0100;
    localparam logic        MIS  = 1'b1;
`else
    localparam logic [31:0] T202 = 32'h0000_0200;
    localparam logic        MIS  = 1'b0;
`endif

    int nvec = 0;
    int nmis = 0;

    fetch_pc_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .trap_i        (trap_i),
        .redirect_i    (redirect_i),
        .redir_base_i  (redir_base_i),
        .redir_off_i   (redir_off_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_ready_i    (if_ready_i),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic        redir;
        logic [31:0] base;
        logic [31:0] off;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(input logic trap, input logic redir, input logic [31:0] base,
                                input logic [31:0] off, input logic gnt, input logic rvalid,
                                input logic [31:0] rdata, input logic ready, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_mis);
        vec_t v;
        v.trap = trap;  v.redir = redir;   v.base = base;   v.off = off;
        v.gnt = gnt;    v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc;  v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction memory content: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic drive_idle();
        trap_i = 1'b0; redirect_i = 1'b0; redir_base_i = '0; redir_off_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; if_ready_i = 1'b0;
    endtask

    vec_t        tbl[$];
    logic [31:0] q[$];
    logic [31:0] model_next;
    logic [31:0] paddr;
    logic [31:0] tgt;
    logic        pending;
    int          cnt;
    int          ndeliv;
    logic        exp_mis, exp_mis_nx;

    initial begin
        // Directed table, one entry per clock starting in the BOOT cycle.
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,    0,32'h0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           1,0,0,0,    1,32'h0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,I0,0,   0,32'h4,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,1,    0,32'h4,1,32'h0,I0,0));
        tbl.push_back(mk(0,0,0,0,           1,0,0,0,    1,32'h4,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,I1,0,   0,32'h8,0,0,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0,0,0,0,       1,0,0,0,    0,32'h8,1,32'h4,I1,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,1,    0,32'h8,1,32'h4,I1,0));
        tbl.push_back(mk(0,0,0,0,           1,0,0,0,    1,32'h8,0,0,0,0));
        tbl.push_back(mk(0,1,32'h100,32'hFFFF_FFF0, 0,0,0,0, 0,32'hC,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,JUNK,1, 0,32'hF0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,    1,32'hF0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h0,32'h40,  1,0,0,0,    1,32'hF0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,JUNK,0, 0,32'h100,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           1,0,0,0,    1,32'h100,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,I2,0,   0,32'h104,0,0,0,0));
        tbl.push_back(mk(0,1,32'h200,32'h2, 0,0,0,1,    0,32'h104,1,32'h100,I2,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,    1,T202,0,0,0,MIS));
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,    1,T202,0,0,0,0));
        tbl.push_back(mk(0,1,32'hFFFF_FFF0,32'hC, 1,0,0,0, 1,T202,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,JUNK,0, 0,32'hFFFF_FFFC,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           1,0,0,0,    1,32'hFFFF_FFFC,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,1,I3,0,   0,32'h0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,1,    0,32'h0,1,32'hFFFF_FFFC,I3,0));
        tbl.push_back(mk(0,0,0,0,           1,0,0,0,    1,32'h0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h300,32'h1, 0,1,I4,0,   0,32'h4,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,    1,32'h300,0,0,0,0));

        reset_n = 1'b0;
        drive_idle();
        #12;
        check("rst req",   32'(imem_req_o),  32'd0);
        check("rst addr",  imem_addr_o,      32'd0);
        check("rst valid", 32'(if_valid_o),  32'd0);
        check("rst pc",    if_pc_o,          32'd0);
        check("rst instr", if_instr_o,       32'd0);
        check("rst mis",   32'(misalign_o),  32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            trap_i = tbl[i].trap;     redirect_i = tbl[i].redir;
            redir_base_i = tbl[i].base; redir_off_i = tbl[i].off;
            imem_gnt_i = tbl[i].gnt;  imem_rvalid_i = tbl[i].rvalid;
            imem_rdata_i = tbl[i].rdata; if_ready_i = tbl[i].ready;
            @(negedge clk);
            check($sformatf("v%0d req", i),   32'(imem_req_o), 32'(tbl[i].e_req));
            check($sformatf("v%0d addr", i),  imem_addr_o,     tbl[i].e_addr);
            check($sformatf("v%0d valid", i), 32'(if_valid_o), 32'(tbl[i].e_valid));
            check($sformatf("v%0d pc", i),    if_pc_o,         tbl[i].e_pc);
            check($sformatf("v%0d instr", i), if_instr_o,      tbl[i].e_instr);
            check($sformatf("v%0d mis", i),   32'(misalign_o), 32'(tbl[i].e_mis));
            @(posedge clk); #1;
        end

        // Asynchronous reset while a fetch is outstanding; the late response must be ignored.
        drive_idle();
        imem_gnt_i = 1'b1;
        @(posedge clk); #1;
        imem_gnt_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst req",   32'(imem_req_o), 32'd0);
        check("midrst addr",  imem_addr_o,     32'd0);
        check("midrst valid", 32'(if_valid_o), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = JUNK;
        @(negedge clk);
        check("late boot req",   32'(imem_req_o), 32'd0);
        check("late boot valid", 32'(if_valid_o), 32'd0);
        @(posedge clk); #1;
        imem_rvalid_i = 1'b1;
        @(negedge clk);
        check("late req",   32'(imem_req_o), 32'd1);
        check("late addr",  imem_addr_o,     32'd0);
        check("late valid", 32'(if_valid_o), 32'd0);
        @(posedge clk); #1;
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("late hold valid", 32'(if_valid_o), 32'd0);

        // Randomized run: model tracks the expected fetch address stream and delivered PCs.
        reset_n = 1'b0;
        drive_idle();
        #3;
        @(posedge clk); #1;
        reset_n    = 1'b1;
        model_next = 32'h0;
        q.delete();
        pending    = 1'b0;
        cnt        = 0;
        paddr      = '0;
        ndeliv     = 0;
        exp_mis    = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            trap_i       = ($urandom_range(0, 63) == 0);
            redirect_i   = ($urandom_range(0, 15) == 0);
            redir_base_i = $urandom;
            redir_off_i  = 32'($urandom_range(0, 255)) - 32'd128;
            imem_gnt_i   = ($urandom_range(0, 2) != 0);
            if_ready_i   = ($urandom_range(0, 3) != 0);
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(paddr);
                    pending       = 1'b0;
                end else begin
                    cnt--;
                end
            end
            @(negedge clk);
            exp_mis_nx = 1'b0;
            check("rnd mis", 32'(misalign_o), 32'(exp_mis));
            if (imem_req_o) check("rnd addr", imem_addr_o, model_next);
            if (if_valid_o) begin
                check("rnd valid pending", 32'(q.size()), 32'd1);
                if (q.size() != 0) begin
                    check("rnd if_pc", if_pc_o, q[0]);
                    check("rnd if_instr", if_instr_o, mem_word(q[0]));
                end
            end
            if (if_valid_o && if_ready_i && !trap_i && !redirect_i && q.size() != 0) begin
                void'(q.pop_front());
                ndeliv++;
            end
            if (trap_i) begin
                model_next = TRAP;
                q.delete();
            end else if (redirect_i) begin
                tgt = redir_base_i + redir_off_i;
`ifdef PC_MISALIGN_TRAP_EN
                if (tgt[1]) begin
                    model_next = TRAP;
                    exp_mis_nx = 1'b1;
                end else begin
                    model_next = tgt & 32'hFFFF_FFFC;
                end
`else
                model_next = tgt & 32'hFFFF_FFFC;
`endif
                q.delete();
            end else if (imem_req_o && imem_gnt_i) begin
                q.push_back(model_next);
                model_next = model_next + 32'd4;
            end
            if (imem_req_o && imem_gnt_i) begin
                pending = 1'b1;
                paddr   = imem_addr_o;
                cnt     = $urandom_range(0, 2);
            end
            exp_mis = exp_mis_nx;
            @(posedge clk); #1;
        end
        check("rnd progress", 32'(ndeliv > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
